// File: rtl/led_panel_pkg.sv
// led_panel_pkg
//   Shared definitions for the LED panel frame loader:
//   - panel geometry (columns, lines, pixel width) and derived address widths
//   - default destination MAC / ethertype accepted by the loader
//   - loader FSM state encoding
//   - framebuffer address packing {bank, line, col}
package led_panel_pkg;

  localparam int COLS   = 64;
  localparam int LINES  = 32;
  localparam int PIX_W  = 8;
  localparam int COL_W  = $clog2(COLS);
  localparam int LINE_W = $clog2(LINES);
  localparam int FB_AW  = 1 + LINE_W + COL_W;

  localparam logic [47:0] DEF_MAC_ADDR = 48'hDAD1D2D3D4D5;
  localparam logic [15:0] DEF_ETH_TYPE = 16'h88B5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LINE_IDX = 2'd1,
    ST_PIXELS   = 2'd2,
    ST_DISCARD  = 2'd3
  } ldr_state_e;

  // Bank is the MSB so each bank occupies one contiguous half of the RAM.
  function automatic logic [FB_AW-1:0] pack_fb_addr(
    input logic              bank,
    input logic [LINE_W-1:0] line,
    input logic [COL_W-1:0]  col
  );
    return {bank, line, col};
  endfunction

endpackage

// File: rtl/fb_bank_swap.sv
// fb_bank_swap
//   Double-buffer bank control. A completed frame raises pending; the next
//   frame_start pulse flips the displayed bank and counts the commit.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   set_pending       - last line of a frame was written cleanly
//   frame_start       - panel driver frame-boundary pulse
//   pending           - a finished back-bank frame is waiting to be shown
//   disp_bank         - bank currently read by the panel driver
//   frames_committed  - number of swaps performed (wraps)
module fb_bank_swap (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_pending,
  input  logic        frame_start,
  output logic        pending,
  output logic        disp_bank,
  output logic [15:0] frames_committed
);

  logic        pending_q, pending_d;
  logic        disp_bank_q, disp_bank_d;
  logic [15:0] commits_q, commits_d;

  // set_pending only fires while a packet is in flight, which cannot happen
  // while pending is already set, so a set and a swap never overlap. A
  // frame_start in the same cycle as set_pending therefore does not swap.
  always_comb begin
    pending_d   = pending_q;
    disp_bank_d = disp_bank_q;
    commits_d   = commits_q;
    if (set_pending) begin
      pending_d = 1'b1;
    end else if (frame_start && pending_q) begin
      pending_d   = 1'b0;
      disp_bank_d = ~disp_bank_q;
      commits_d   = commits_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= 1'b0;
      disp_bank_q <= 1'b0;
      commits_q   <= 16'd0;
    end else begin
      pending_q   <= pending_d;
      disp_bank_q <= disp_bank_d;
      commits_q   <= commits_d;
    end
  end

  assign pending          = pending_q;
  assign disp_bank        = disp_bank_q;
  assign frames_committed = commits_q;

endmodule

// File: rtl/led_frame_loader.sv
// led_frame_loader
//   Filters parsed Ethernet packets by destination MAC and ethertype and writes
//   each accepted packet (byte 0 = line index, then COLS pixels) as one line
//   into the back bank of a double-buffered framebuffer. A cleanly written
//   last line marks the frame complete; the banks swap on the next frame_start.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   s_hdr_valid/ready, s_dest_mac,
//   s_eth_type                     - parsed header handshake
//   s_payload_t{data,valid,ready,
//   last,user}                     - payload stream, tuser = bad frame (with tlast)
//   frame_start                    - panel driver frame-boundary pulse
//   fb_wr_en/addr/data             - registered framebuffer write port
//   disp_bank                      - bank read by the panel driver
//   frames_committed, drop_count   - wrapping statistics counters
module led_frame_loader
  import led_panel_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR = DEF_MAC_ADDR,
  parameter logic [15:0] ETH_TYPE = DEF_ETH_TYPE,
  parameter int          COLS     = led_panel_pkg::COLS,
  parameter int          LINES    = led_panel_pkg::LINES,
  parameter int          AW       = 1 + $clog2(LINES) + $clog2(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_hdr_valid,
  output logic          s_hdr_ready,
  input  logic [47:0]   s_dest_mac,
  input  logic [15:0]   s_eth_type,
  input  logic [7:0]    s_payload_tdata,
  input  logic          s_payload_tvalid,
  output logic          s_payload_tready,
  input  logic          s_payload_tlast,
  input  logic          s_payload_tuser,
  input  logic          frame_start,
  output logic          fb_wr_en,
  output logic [AW-1:0] fb_wr_addr,
  output logic [7:0]    fb_wr_data,
  output logic          disp_bank,
  output logic [15:0]   frames_committed,
  output logic [15:0]   drop_count
);

  localparam int CW = $clog2(COLS);
  localparam int LW = $clog2(LINES);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(LINES - 1);

  ldr_state_e    state_q, state_d;
  logic          wbank_q, wbank_d;
  logic [LW-1:0] line_q, line_d;
  logic [CW-1:0] col_q, col_d;
  logic [15:0]   drop_count_q, drop_count_d;
  logic          fb_wr_en_q, fb_wr_en_d;
  logic [AW-1:0] fb_wr_addr_q, fb_wr_addr_d;
  logic [7:0]    fb_wr_data_q, fb_wr_data_d;

  logic pending;
  logic set_pending;
  logic drop;
  logic beat;
  logic hdr_match;

  assign hdr_match = (s_dest_mac == MAC_ADDR) && (s_eth_type == ETH_TYPE);

  always_comb begin
    state_d      = state_q;
    wbank_d      = wbank_q;
    line_d       = line_q;
    col_d        = col_q;
    drop_count_d = drop_count_q;
    fb_wr_en_d   = 1'b0;
    fb_wr_addr_d = fb_wr_addr_q;
    fb_wr_data_d = fb_wr_data_q;
    set_pending  = 1'b0;
    drop         = 1'b0;

    // Holding off headers while a frame waits for display keeps the shown
    // bank untouched and guarantees a swap never lands mid-packet.
    s_hdr_ready      = (state_q == ST_IDLE) && !pending;
    s_payload_tready = (state_q != ST_IDLE);
    beat             = s_payload_tvalid && s_payload_tready;

    unique case (state_q)
      ST_IDLE: begin
        if (s_hdr_valid && s_hdr_ready) begin
          if (hdr_match) begin
            wbank_d = ~disp_bank;
            state_d = ST_LINE_IDX;
          end else begin
            // Traffic for someone else is drained silently, not counted.
            state_d = ST_DISCARD;
          end
        end
      end

      ST_LINE_IDX: begin
        if (beat) begin
          if (s_payload_tlast) begin
            drop    = 1'b1;
            state_d = ST_IDLE;
          end else if ({24'd0, s_payload_tdata} >= LINES) begin
            drop    = 1'b1;
            state_d = ST_DISCARD;
          end else begin
            line_d  = s_payload_tdata[LW-1:0];
            col_d   = '0;
            state_d = ST_PIXELS;
          end
        end
      end

      ST_PIXELS: begin
        if (beat) begin
          fb_wr_en_d   = 1'b1;
          fb_wr_addr_d = pack_fb_addr(wbank_q, line_q, col_q);
          fb_wr_data_d = s_payload_tdata;
          col_d        = col_q + CW'(1);
          if (s_payload_tlast) begin
            state_d = ST_IDLE;
            if ((col_q == COL_LAST) && !s_payload_tuser) begin
              if (line_q == LINE_LAST) begin
                set_pending = 1'b1;
              end
            end else begin
              // Short or flagged-bad line: pixels already written stay.
              drop = 1'b1;
            end
          end else if (col_q == COL_LAST) begin
            // Over-long packet: line is full, throw away the excess.
            drop    = 1'b1;
            state_d = ST_DISCARD;
          end
        end
      end

      ST_DISCARD: begin
        if (beat && s_payload_tlast) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (drop) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wbank_q      <= 1'b0;
      line_q       <= '0;
      col_q        <= '0;
      drop_count_q <= 16'd0;
      fb_wr_en_q   <= 1'b0;
      fb_wr_addr_q <= '0;
      fb_wr_data_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      wbank_q      <= wbank_d;
      line_q       <= line_d;
      col_q        <= col_d;
      drop_count_q <= drop_count_d;
      fb_wr_en_q   <= fb_wr_en_d;
      fb_wr_addr_q <= fb_wr_addr_d;
      fb_wr_data_q <= fb_wr_data_d;
    end
  end

  fb_bank_swap u_bank_swap (
    .clk              (clk),
    .rst              (rst),
    .set_pending      (set_pending),
    .frame_start      (frame_start),
    .pending          (pending),
    .disp_bank        (disp_bank),
    .frames_committed (frames_committed)
  );

  assign fb_wr_en   = fb_wr_en_q;
  assign fb_wr_addr = fb_wr_addr_q;
  assign fb_wr_data = fb_wr_data_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_led_frame_loader.sv
module tb_led_frame_loader;

  localparam logic [47:0] GOOD_MAC  = 48'hDAD1D2D3D4D5;
  localparam logic [15:0] GOOD_TYPE = 16'h88B5;
  localparam int N_COLS  = 64;
  localparam int N_LINES = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_hdr_valid;
  logic        s_hdr_ready;
  logic [47:0] s_dest_mac;
  logic [15:0] s_eth_type;
  logic [7:0]  s_payload_tdata;
  logic        s_payload_tvalid;
  logic        s_payload_tready;
  logic        s_payload_tlast;
  logic        s_payload_tuser;
  logic        frame_start;
  logic        fb_wr_en;
  logic [11:0] fb_wr_addr;
  logic [7:0]  fb_wr_data;
  logic        disp_bank;
  logic [15:0] frames_committed;
  logic [15:0] drop_count;

  led_frame_loader dut (
    .clk              (clk),
    .rst              (rst),
    .s_hdr_valid      (s_hdr_valid),
    .s_hdr_ready      (s_hdr_ready),
    .s_dest_mac       (s_dest_mac),
    .s_eth_type       (s_eth_type),
    .s_payload_tdata  (s_payload_tdata),
    .s_payload_tvalid (s_payload_tvalid),
    .s_payload_tready (s_payload_tready),
    .s_payload_tlast  (s_payload_tlast),
    .s_payload_tuser  (s_payload_tuser),
    .frame_start      (frame_start),
    .fb_wr_en         (fb_wr_en),
    .fb_wr_addr       (fb_wr_addr),
    .fb_wr_data       (fb_wr_data),
    .disp_bank        (disp_bank),
    .frames_committed (frames_committed),
    .drop_count       (drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Observed framebuffer writes, sampled on the falling edge.
  logic [19:0] obs_q[$];
  int          obs_cyc_q[$];
  always @(negedge clk) begin
    if (fb_wr_en === 1'b1) begin
      obs_q.push_back({fb_wr_addr, fb_wr_data});
      obs_cyc_q.push_back(cyc);
    end
  end

  // Reference model state
  logic        m_disp_bank = 1'b0;
  bit          m_pending   = 1'b0;
  logic [15:0] m_drops     = 16'd0;
  logic [15:0] m_commits   = 16'd0;
  logic [19:0] exp_q[$];
  int          beat_cyc[$];

  // Computes the expected outcome of one packet straight from the packet rules.
  task automatic model_packet(input logic [47:0] mac, input logic [15:0] typ,
                              input logic [7:0] bytes[$], input bit tuser);
    int line, npix, nwr;
    logic [11:0] a;
    exp_q.delete();
    if (mac != GOOD_MAC || typ != GOOD_TYPE) return;
    if (bytes.size() == 1) begin m_drops++; return; end
    line = int'(bytes[0]);
    if (line >= N_LINES) begin m_drops++; return; end
    npix = bytes.size() - 1;
    nwr  = (npix < N_COLS) ? npix : N_COLS;
    for (int i = 0; i < nwr; i++) begin
      a = 12'((m_disp_bank ? 0 : 1) * 2048 + line * 64 + i);
      exp_q.push_back({a, bytes[i+1]});
    end
    if (npix == N_COLS && !tuser) begin
      if (line == N_LINES - 1) m_pending = 1'b1;
    end else begin
      m_drops++;
    end
  endtask

  function automatic bit writes_match();
    if (obs_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) begin
      if (obs_q[i] !== exp_q[i]) return 1'b0;
      if (obs_cyc_q[i] != beat_cyc[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic send_packet(input logic [47:0] mac, input logic [15:0] typ,
                             input int npix, input logic [7:0] line, input bit tuser,
                             input bit gaps, input bit fs_last, input bit seq);
    logic [7:0] bytes[$];
    int waitc;
    bit last;
    obs_q.delete();
    obs_cyc_q.delete();
    beat_cyc.delete();
    bytes.push_back(line);
    for (int i = 0; i < npix; i++) bytes.push_back(seq ? 8'(i) : 8'($urandom));
    model_packet(mac, typ, bytes, tuser);

    s_dest_mac  = mac;
    s_eth_type  = typ;
    s_hdr_valid = 1'b1;
    waitc = 0;
    while (s_hdr_ready !== 1'b1 && waitc < 200) begin
      @(posedge clk); #1; waitc++;
    end
    if (waitc >= 200) begin
      vectors++; miscompares++;
      $display("FAIL hdr_accept_timeout: s_hdr_ready=%b after %0d cycles, required 1", s_hdr_ready, waitc);
      s_hdr_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_hdr_valid = 1'b0;
    s_dest_mac  = 48'($urandom);

    for (int i = 0; i < bytes.size(); i++) begin
      if (gaps && $urandom_range(3) == 0) begin @(posedge clk); #1; end
      last = (i == bytes.size() - 1);
      s_payload_tdata  = bytes[i];
      s_payload_tvalid = 1'b1;
      s_payload_tlast  = last;
      s_payload_tuser  = last ? tuser : 1'($urandom);
      frame_start      = fs_last && last;
      waitc = 0;
      while (s_payload_tready !== 1'b1 && waitc < 50) begin
        @(posedge clk); #1; waitc++;
      end
      if (waitc >= 50) begin
        vectors++; miscompares++;
        $display("FAIL payload_timeout: s_payload_tready=%b at byte %0d, required 1", s_payload_tready, i);
      end
      @(posedge clk); #1;
      if (i > 0) beat_cyc.push_back(cyc);
      s_payload_tvalid = 1'b0;
      s_payload_tlast  = 1'b0;
      s_payload_tuser  = 1'b0;
      frame_start      = 1'b0;
    end
    repeat (2) begin @(posedge clk); #1; end
    $display("pkt mac_ok=%0b line=%0d npix=%0d tuser=%0b writes=%0d exp_writes=%0d drops=%0d",
             (mac == GOOD_MAC && typ == GOOD_TYPE), line, npix, tuser, obs_q.size(), exp_q.size(), drop_count);
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    if (m_pending) begin
      m_pending   = 1'b0;
      m_disp_bank = ~m_disp_bank;
      m_commits++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    vectors++; if (s_hdr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_hdr_ready: got %b, required 1", s_hdr_ready); end
    vectors++; if (s_payload_tready !== 1'b0) begin miscompares++; $display("FAIL reset_tready: got %b, required 0", s_payload_tready); end
    vectors++; if (fb_wr_en !== 1'b0 || fb_wr_addr !== 12'h000 || fb_wr_data !== 8'h00) begin
      miscompares++; $display("FAIL reset_wr_port: got en=%b addr=%h data=%h, required 0/000/00", fb_wr_en, fb_wr_addr, fb_wr_data); end
    vectors++; if (disp_bank !== 1'b0 || frames_committed !== 16'd0 || drop_count !== 16'd0) begin
      miscompares++; $display("FAIL reset_state: got bank=%b commits=%0d drops=%0d, required 0/0/0", disp_bank, frames_committed, drop_count); end
  endtask

  task automatic test_good_packet();
    send_packet(GOOD_MAC, GOOD_TYPE, 64, 8'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    vectors++; if (!writes_match()) begin miscompares++;
      $display("FAIL good_writes: got %0d writes, required %0d with matching addr/data/latency", obs_q.size(), exp_q.size()); end
    vectors++; if (obs_q.size() != 64 || obs_q[0] !== {12'h940, 8'h00} || obs_q[63] !== {12'h97F, 8'h3F}) begin miscompares++;
      $display("FAIL good_bounds: got n=%0d first=%h last=%h, required 64 94000 97F3F", obs_q.size(), obs_q[0], obs_q[63]); end
    vectors++; if (drop_count !== 16'd0) begin miscompares++; $display("FAIL good_drops: got %0d, required 0", drop_count); end
  endtask

  task automatic test_wrong_mac();
    send_packet(48'h010203040506, GOOD_TYPE, 64, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL wrong_mac_writes: got %0d, required 0", obs_q.size()); end
    vectors++; if (drop_count !== m_drops) begin miscompares++; $display("FAIL wrong_mac_drops: got %0d, required %0d", drop_count, m_drops); end
    send_packet(GOOD_MAC, 16'h0800, 20, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++; if (obs_q.size() != 0 || drop_count !== m_drops) begin miscompares++;
      $display("FAIL wrong_type: got writes=%0d drops=%0d, required 0/%0d", obs_q.size(), drop_count, m_drops); end
    vectors++; if (s_hdr_ready !== 1'b1 || s_payload_tready !== 1'b0) begin miscompares++;
      $display("FAIL wrong_drained: got hdr_ready=%b tready=%b, required 1/0", s_hdr_ready, s_payload_tready); end
  endtask

  task automatic test_bad_line();
    send_packet(GOOD_MAC, GOOD_TYPE, 64, 8'd40, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL bad_line_writes: got %0d, required 0", obs_q.size()); end
    vectors++; if (drop_count !== 16'd1) begin miscompares++; $display("FAIL bad_line_drops: got %0d, required 1", drop_count); end
  endtask

  task automatic test_short();
    send_packet(GOOD_MAC, GOOD_TYPE, 10, 8'd31, 1'b0, 1'b1, 1'b0, 1'b0);
    vectors++; if (!writes_match() || obs_q.size() != 10) begin miscompares++;
      $display("FAIL short_writes: got %0d writes, required 10 matching", obs_q.size()); end
    vectors++; if (drop_count !== m_drops) begin miscompares++; $display("FAIL short_drops: got %0d, required %0d", drop_count, m_drops); end
    vectors++; if (s_hdr_ready !== 1'b1) begin miscompares++; $display("FAIL short_pending: hdr_ready=%b, required 1", s_hdr_ready); end
  endtask

  task automatic test_tuser();
    send_packet(GOOD_MAC, GOOD_TYPE, 64, 8'd31, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++; if (!writes_match() || obs_q.size() != 64) begin miscompares++;
      $display("FAIL tuser_writes: got %0d writes, required 64 matching", obs_q.size()); end
    vectors++; if (drop_count !== m_drops || s_hdr_ready !== 1'b1) begin miscompares++;
      $display("FAIL tuser_drop: got drops=%0d hdr_ready=%b, required %0d/1", drop_count, s_hdr_ready, m_drops); end
    pulse_frame_start();
    vectors++; if (disp_bank !== 1'b0 || frames_committed !== m_commits) begin miscompares++;
      $display("FAIL tuser_noswap: got bank=%b commits=%0d, required 0/%0d", disp_bank, frames_committed, m_commits); end
  endtask

  task automatic test_full_frame();
    for (int l = 0; l < N_LINES; l++) begin
      send_packet(GOOD_MAC, GOOD_TYPE, 64, 8'(l), 1'b0, 1'($urandom), (l == N_LINES - 1), 1'b0);
      vectors++; if (!writes_match()) begin miscompares++;
        $display("FAIL frame_line_writes: line %0d got %0d writes, required %0d matching", l, obs_q.size(), exp_q.size()); end
    end
    // frame_start shared the final beat's cycle: must not swap yet.
    vectors++; if (s_hdr_ready !== 1'b0 || disp_bank !== m_disp_bank) begin miscompares++;
      $display("FAIL frame_pending: got hdr_ready=%b bank=%b, required 0/%b", s_hdr_ready, disp_bank, m_disp_bank); end
    s_dest_mac = GOOD_MAC; s_eth_type = GOOD_TYPE; s_hdr_valid = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    vectors++; if (s_hdr_ready !== 1'b0 || s_payload_tready !== 1'b0) begin miscompares++;
      $display("FAIL frame_stall: got hdr_ready=%b tready=%b, required 0/0", s_hdr_ready, s_payload_tready); end
    s_hdr_valid = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    vectors++; if (disp_bank !== 1'b0) begin miscompares++; $display("FAIL frame_early_swap: got bank=%b, required 0", disp_bank); end
    @(posedge clk); #1;
    frame_start = 1'b0;
    m_pending = 1'b0; m_disp_bank = ~m_disp_bank; m_commits++;
    vectors++; if (disp_bank !== 1'b1 || frames_committed !== 16'd1 || s_hdr_ready !== 1'b1) begin miscompares++;
      $display("FAIL frame_swap: got bank=%b commits=%0d hdr_ready=%b, required 1/1/1", disp_bank, frames_committed, s_hdr_ready); end
  endtask

  task automatic test_rst_mid();
    vectors++; if (disp_bank !== m_disp_bank || frames_committed !== m_commits || drop_count !== m_drops) begin miscompares++;
      $display("FAIL rst_pre_state: got bank=%b commits=%0d drops=%0d, required %b/%0d/%0d",
               disp_bank, frames_committed, drop_count, m_disp_bank, m_commits, m_drops); end
    s_dest_mac = GOOD_MAC; s_eth_type = GOOD_TYPE; s_hdr_valid = 1'b1;
    @(posedge clk); #1;
    s_hdr_valid = 1'b0;
    s_payload_tvalid = 1'b1;
    s_payload_tdata  = 8'd7;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      s_payload_tdata = 8'($urandom);
      @(posedge clk); #1;
    end
    s_payload_tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++; if (s_payload_tready !== 1'b0 || s_hdr_ready !== 1'b1 || fb_wr_en !== 1'b0) begin miscompares++;
      $display("FAIL rst_fsm: got tready=%b hdr_ready=%b wr_en=%b, required 0/1/0", s_payload_tready, s_hdr_ready, fb_wr_en); end
    vectors++; if (disp_bank !== 1'b0 || frames_committed !== 16'd0 || drop_count !== 16'd0) begin miscompares++;
      $display("FAIL rst_state: got bank=%b commits=%0d drops=%0d, required 0/0/0", disp_bank, frames_committed, drop_count); end
    rst = 1'b0;
    m_disp_bank = 1'b0; m_pending = 1'b0; m_drops = 16'd0; m_commits = 16'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [47:0] mac;
    logic [15:0] typ;
    logic [7:0]  line;
    int npix;
    for (int n = 0; n < 60; n++) begin
      if (m_pending || $urandom_range(4) == 0) pulse_frame_start();
      mac  = GOOD_MAC;
      typ  = GOOD_TYPE;
      if ($urandom_range(5) == 0) begin
        if ($urandom_range(1) == 0) mac = {16'($urandom), 32'($urandom)};
        else typ = 16'($urandom);
      end
      case ($urandom_range(9))
        0, 1:    line = 8'd31;
        2:       line = 8'($urandom_range(255, 32));
        default: line = 8'($urandom_range(31));
      endcase
      npix = ($urandom_range(9) < 6) ? 64 : $urandom_range(80);
      send_packet(mac, typ, npix, line, ($urandom_range(7) == 0), 1'($urandom), 1'b0, 1'b0);
      vectors++; if (!writes_match()) begin miscompares++;
        $display("FAIL rand_writes: pkt %0d got %0d writes, required %0d matching", n, obs_q.size(), exp_q.size()); end
      vectors++; if (drop_count !== m_drops || frames_committed !== m_commits) begin miscompares++;
        $display("FAIL rand_counters: pkt %0d got drops=%0d commits=%0d, required %0d/%0d", n, drop_count, frames_committed, m_drops, m_commits); end
      vectors++; if (disp_bank !== m_disp_bank || s_hdr_ready !== !m_pending) begin miscompares++;
        $display("FAIL rand_bank: pkt %0d got bank=%b hdr_ready=%b, required %b/%b", n, disp_bank, s_hdr_ready, m_disp_bank, !m_pending); end
    end
  endtask

  initial begin
    rst = 1'b1;
    s_hdr_valid = 1'b0;
    s_dest_mac = '0;
    s_eth_type = '0;
    s_payload_tdata = '0;
    s_payload_tvalid = 1'b0;
    s_payload_tlast = 1'b0;
    s_payload_tuser = 1'b0;
    frame_start = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_good_packet();
    test_wrong_mac();
    test_bad_line();
    test_short();
    test_tuser();
    test_full_frame();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/led_frame_loader.md
# led_frame_loader

Sequences received Ethernet pixel packets into a double-buffered LED panel framebuffer. Sits between the Ethernet frame parser (header + payload AXI-Stream) and the framebuffer RAM read by the panel driver. Accepts only frames addressed to the panel's MAC and ethertype, and writes one 64-pixel line per packet into the back bank. After a complete frame (last line written cleanly), it swaps banks on the panel driver's next `frame_start`.

## Interface
Parameters:
- `MAC_ADDR`, 48'hDAD1D2D3D4D5, accepted destination MAC
- `ETH_TYPE`, 16'h88B5, accepted ethertype
- `COLS`, 64, pixels per line (one RGB332 byte each)
- `LINES`, 32, lines per frame
- `AW`, 12, framebuffer address width = 1 + log2(LINES) + log2(COLS)

Ports:
- `clk` in 1, single clock for the whole block
- `rst` in 1, reset; synchronous, active-high
- `s_hdr_valid` in 1, parsed header valid
- `s_hdr_ready` out 1, header accept
- `s_dest_mac` in 48, destination MAC
- `s_eth_type` in 16, ethertype
- `s_payload_tdata` in 8, payload byte
- `s_payload_tvalid` in 1, payload valid
- `s_payload_tready` out 1, payload accept
- `s_payload_tlast` in 1, last payload byte
- `s_payload_tuser` in 1, bad-frame flag, qualified with tlast
- `frame_start` in 1, one-cycle pulse from panel driver at frame boundary
- `fb_wr_en` out 1, framebuffer write strobe
- `fb_wr_addr` out AW, {bank, line, col}
- `fb_wr_data` out 8, pixel byte
- `disp_bank` out 1, bank the panel driver reads
- `frames_committed` out 16, swap count, wraps
- `drop_count` out 16, rejected/bad packet count, wraps

## Operation
- Packet payload format: byte 0 = line index; bytes 1..COLS = pixels, col 0 first.
- FSM states: IDLE, LINE_IDX, PIXELS, DISCARD.
- IDLE:
  - `s_hdr_ready` = !pending.
  - On header accept with MAC and type both matching: latch `wbank` = ~disp_bank, go to LINE_IDX.
  - On header accept with a mismatch: go to DISCARD. No drop count.
- `s_payload_tready` = 1 in LINE_IDX, PIXELS and DISCARD; 0 in IDLE.
- LINE_IDX, on beat:
  - tlast: drop++, go to IDLE.
  - tdata >= LINES: drop++, go to DISCARD.
  - Otherwise: latch line, col = 0, go to PIXELS.
- PIXELS, each beat: write {wbank, line, col} ← tdata, then col++.
  - tlast with col == COLS-1 and !tuser: good line. If line == LINES-1, set pending. Go to IDLE.
  - tlast otherwise (short packet or tuser=1): drop++, go to IDLE. Bytes already written stay written.
  - col == COLS-1 without tlast: drop++, go to DISCARD.
- DISCARD: consume beats until tlast, then go to IDLE. Never writes.
- Swap: when `frame_start` && pending: toggle `disp_bank`, clear pending, frames_committed++.
- While pending, no new headers are accepted. A swap therefore never coincides with a packet in flight, and the displayed bank is never written.

## Timing
- Reset values:
  - state = IDLE, pending = 0, `disp_bank` = 0.
  - Both counters = 0.
  - `fb_wr_en` = 0; `fb_wr_addr` and `fb_wr_data` = 0.
  - `s_payload_tready` = 0; `s_hdr_ready` = 1.
- Write path is registered: `fb_wr_*` is asserted the cycle after the accepted beat, with 1-cycle latency.
- pending is set the cycle after the final good beat. A `frame_start` in that same beat cycle does not swap; the next pulse does.
- `disp_bank` and `frames_committed` update the cycle after `frame_start`.
- `rst` asserted mid-packet returns to IDLE immediately. The remainder of that packet is not drained; the upstream parser resets on the same `rst`.
- A drop and the end of a good line are mutually exclusive per packet; a counter increments at most once per cycle.

## Structure
- Shared package `led_panel_pkg`:
  - panel geometry constants (COLS, LINES, pixel width 8)
  - MAC/ethertype defaults
  - FSM state encoding
  - address packing function {bank, line, col}
- Single module. No sub-module required; the swap logic (pending, `disp_bank`, commit counter) may be split into `fb_bank_swap` if preferred.

## Test plan
- Good packet: MAC DAD1D2D3D4D5, type 88B5, line 5, pixels 0x00..0x3F -> 64 writes at addresses 0x940..0x97F (bank 1), drop_count 0.
- Full frame: lines 0..31 good, then `frame_start` -> disp_bank 0→1 one cycle later, frames_committed = 1. A following header stalls (`s_hdr_ready` = 0) until that pulse.
- Wrong MAC (0x010203040506) -> no writes, payload drained, drop_count unchanged.
- Line index 40 -> DISCARD, no writes, drop_count = 1. Short packet (line 31, 10 pixels) -> 10 writes, drop_count +1, no pending.
- tuser = 1 on the last beat of line 31 -> 64 writes, no pending; `frame_start` leaves disp_bank unchanged.
- `rst` pulse at pixel 20 -> FSM IDLE, tready 0, `disp_bank` and counters return to 0 the next cycle.
